// File: rtl/memtrace_pkg.sv
// memtrace_pkg: widths and entry format shared by the memory-trace source and its consumers
package memtrace_pkg;
    localparam int DATA_WIDTH    = 64;
    localparam int LOGSIZE_WIDTH = 32;
    typedef struct packed {
        logic [DATA_WIDTH-1:0]    address;
        logic                     is_store;
        logic [LOGSIZE_WIDTH-1:0] size;
        logic [DATA_WIDTH-1:0]    data;
    } memtrace_entry_t;
endpackage

// File: rtl/memtrace_lane_fifo.sv
// memtrace_lane_fifo: per-lane trace entry FIFO with occupancy outputs
module memtrace_lane_fifo
    import memtrace_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = memtrace_entry_t,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  entry_t        din,
    output entry_t        dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    // Storage needs no reset: the reader only looks at dout while the FIFO is non-empty.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/memtrace_req_issuer.sv
// memtrace_req_issuer: turns per-lane trace entries into tagged memory requests,
// tracking outstanding tags per lane and flagging completion and protocol errors.
module memtrace_req_issuer #(
    parameter int  NUM_LANES     = 4,
    parameter int  DATA_WIDTH    = memtrace_pkg::DATA_WIDTH,
    parameter int  LOGSIZE_WIDTH = memtrace_pkg::LOGSIZE_WIDTH,
    parameter int  FIFO_DEPTH    = 4,
    parameter int  MAX_INFLIGHT  = 8,
    localparam int SRC_W         = $clog2(MAX_INFLIGHT)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_LANES-1:0]               trace_valid,
    input  logic [DATA_WIDTH*NUM_LANES-1:0]    trace_address,
    input  logic [NUM_LANES-1:0]               trace_is_store,
    input  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] trace_size,
    input  logic [DATA_WIDTH*NUM_LANES-1:0]    trace_data,
    input  logic                               trace_finished,
    output logic                               trace_ready,
    output logic [NUM_LANES-1:0]               req_valid,
    input  logic [NUM_LANES-1:0]               req_ready,
    output logic [DATA_WIDTH*NUM_LANES-1:0]    req_address,
    output logic [NUM_LANES-1:0]               req_is_store,
    output logic [LOGSIZE_WIDTH*NUM_LANES-1:0] req_size,
    output logic [DATA_WIDTH*NUM_LANES-1:0]    req_data,
    output logic [SRC_W*NUM_LANES-1:0]         req_source,
    input  logic [NUM_LANES-1:0]               resp_valid,
    input  logic [SRC_W*NUM_LANES-1:0]         resp_source,
    output logic                               done,
    output logic                               err
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0]    address;
        logic                     is_store;
        logic [LOGSIZE_WIDTH-1:0] size;
        logic [DATA_WIDTH-1:0]    data;
    } entry_t;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    logic [NUM_LANES-1:0] full, empty, resp_bad, drained;
    logic                 finished_seen;
    // A single ready serves all lanes, so any full lane stalls the whole trace.
    assign trace_ready = ~|full;
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        entry_t                  din, dout;
        logic [CW-1:0]           count;
        logic [MAX_INFLIGHT-1:0] free_mask, issue_oh, resp_oh;
        logic [SRC_W-1:0]        src, rsrc;
        logic                    fire;
        assign din  = {trace_address[g*DATA_WIDTH +: DATA_WIDTH], trace_is_store[g],
                       trace_size[g*LOGSIZE_WIDTH +: LOGSIZE_WIDTH], trace_data[g*DATA_WIDTH +: DATA_WIDTH]};
        assign rsrc = resp_source[g*SRC_W +: SRC_W];
        always_comb begin
            src = '0;
            for (int i = MAX_INFLIGHT - 1; i >= 0; i--)
                if (free_mask[i]) src = SRC_W'(i);
        end
        assign req_valid[g]  = !empty[g] && |free_mask;
        assign fire          = req_valid[g] && req_ready[g];
        assign issue_oh      = fire ? MAX_INFLIGHT'(1) << src : '0;
        assign resp_bad[g]   = resp_valid[g] && free_mask[rsrc];
        assign resp_oh       = resp_valid[g] && !free_mask[rsrc] ? MAX_INFLIGHT'(1) << rsrc : '0;
        assign drained[g]    = count == '0 && &free_mask;
        // Issue picks from the pre-update mask; a freed tag becomes visible next cycle.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) free_mask <= '1;
            else free_mask <= (free_mask & ~issue_oh) | resp_oh;
        end
        memtrace_lane_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (trace_ready && trace_valid[g]),
            .pop   (fire),
            .din   (din),
            .dout  (dout),
            .count (count),
            .full  (full[g]),
            .empty (empty[g])
        );
        assign req_source[g*SRC_W +: SRC_W]                 = src;
        assign req_address[g*DATA_WIDTH +: DATA_WIDTH]      = req_valid[g] ? dout.address : '0;
        assign req_is_store[g]                              = req_valid[g] && dout.is_store;
        assign req_size[g*LOGSIZE_WIDTH +: LOGSIZE_WIDTH]   = req_valid[g] ? dout.size : '0;
        assign req_data[g*DATA_WIDTH +: DATA_WIDTH]         = req_valid[g] ? dout.data : '0;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            finished_seen <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            finished_seen <= finished_seen | trace_finished;
            done          <= done | (finished_seen & &drained);
            err           <= err | |resp_bad;
        end
    end
endmodule
